// File: rtl/frame_buffer_controller.sv
// -----------------------------------------------------------------------------
// frame_buffer_controller
//
// Sequences an external 3x3 neighbourhood frame buffer for the colorspace/edge
// pipeline. It accepts a raster pixel stream (valid/ready) and writes it
// row-major into the buffer until the frame is full. It then sweeps every
// center position, issuing one buffer read per position, and presents each
// resulting 8-pixel neighbourhood to the Sobel stage over valid/ready. After
// the last matrix of the frame is accepted it returns to filling.
//
// Optional feature (macro FBC_SKIP_BORDER_EN):
//   defined   - the read sweep covers only the interior rows 1..P_ROWS-2 and
//               columns 1..P_COLUMNS-2, so no presented matrix has
//               zero-padded neighbours.
//   undefined - full sweep (0,0)..(P_ROWS-1, P_COLUMNS-1).
//
// Ports:
//   I_CLK, I_RESET        clock, synchronous active-high reset
//   I_PIXEL, I_PIXEL_VALID, O_PIXEL_READY
//                         upstream pixel stream
//   O_BUF_COLUMN, O_BUF_ROW, O_BUF_PIXEL, O_BUF_WRITE_ENABLE, O_BUF_READ_ENABLE
//                         buffer address, write data and strobes
//   O_MATRIX_VALID, I_MATRIX_READY
//                         downstream handshake for the buffer's matrix output
//   O_CENTER_COLUMN, O_CENTER_ROW
//                         center position of the presented matrix
//   O_FRAME_DONE          1-cycle pulse when the last matrix is accepted
// -----------------------------------------------------------------------------
module frame_buffer_controller #(
    parameter int P_COLUMNS     = 640,
    parameter int P_ROWS        = 4,
    parameter int P_PIXEL_DEPTH = 8,
    localparam int COL_W = (P_COLUMNS > 1) ? $clog2(P_COLUMNS) : 1,
    localparam int ROW_W = (P_ROWS > 1) ? $clog2(P_ROWS) : 1
) (
    input  logic                     I_CLK,
    input  logic                     I_RESET,
    input  logic [P_PIXEL_DEPTH-1:0] I_PIXEL,
    input  logic                     I_PIXEL_VALID,
    output logic                     O_PIXEL_READY,
    output logic [COL_W-1:0]         O_BUF_COLUMN,
    output logic [ROW_W-1:0]         O_BUF_ROW,
    output logic [P_PIXEL_DEPTH-1:0] O_BUF_PIXEL,
    output logic                     O_BUF_WRITE_ENABLE,
    output logic                     O_BUF_READ_ENABLE,
    output logic                     O_MATRIX_VALID,
    input  logic                     I_MATRIX_READY,
    output logic [COL_W-1:0]         O_CENTER_COLUMN,
    output logic [ROW_W-1:0]         O_CENTER_ROW,
    output logic                     O_FRAME_DONE
);

    // Write sweep always covers the whole frame.
    localparam logic [COL_W-1:0] WR_COL_LAST = COL_W'(P_COLUMNS - 1);
    localparam logic [ROW_W-1:0] WR_ROW_LAST = ROW_W'(P_ROWS - 1);

    // Read sweep bounds depend on whether border centers are skipped.
`ifdef FBC_SKIP_BORDER_EN
    localparam logic [COL_W-1:0] RD_COL_FIRST = COL_W'(1);
    localparam logic [ROW_W-1:0] RD_ROW_FIRST = ROW_W'(1);
    localparam logic [COL_W-1:0] RD_COL_LAST  = COL_W'(P_COLUMNS - 2);
    localparam logic [ROW_W-1:0] RD_ROW_LAST  = ROW_W'(P_ROWS - 2);
`else
    localparam logic [COL_W-1:0] RD_COL_FIRST = '0;
    localparam logic [ROW_W-1:0] RD_ROW_FIRST = '0;
    localparam logic [COL_W-1:0] RD_COL_LAST  = COL_W'(P_COLUMNS - 1);
    localparam logic [ROW_W-1:0] RD_ROW_LAST  = ROW_W'(P_ROWS - 1);
`endif

    typedef enum logic [1:0] {
        FILL       = 2'd0,
        READ_ISSUE = 2'd1,
        READ_HOLD  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [COL_W-1:0] wr_col_reg, wr_col_next;
    logic [ROW_W-1:0] wr_row_reg, wr_row_next;
    logic [COL_W-1:0] rd_col_reg, rd_col_next;
    logic [ROW_W-1:0] rd_row_reg, rd_row_next;

    logic pixel_ready;
    logic write_enable;
    logic read_enable;
    logic matrix_valid;
    logic frame_done;

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            state_reg  <= FILL;
            wr_col_reg <= '0;
            wr_row_reg <= '0;
            rd_col_reg <= RD_COL_FIRST;
            rd_row_reg <= RD_ROW_FIRST;
        end else begin
            state_reg  <= state_next;
            wr_col_reg <= wr_col_next;
            wr_row_reg <= wr_row_next;
            rd_col_reg <= rd_col_next;
            rd_row_reg <= rd_row_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        wr_col_next  = wr_col_reg;
        wr_row_next  = wr_row_reg;
        rd_col_next  = rd_col_reg;
        rd_row_next  = rd_row_reg;
        pixel_ready  = 1'b0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        matrix_valid = 1'b0;
        frame_done   = 1'b0;
        O_BUF_COLUMN = wr_col_reg;
        O_BUF_ROW    = wr_row_reg;

        case (state_reg)
            FILL: begin
                pixel_ready = 1'b1;
                if (I_PIXEL_VALID) begin
                    write_enable = 1'b1;
                    if (wr_col_reg == WR_COL_LAST) begin
                        wr_col_next = '0;
                        if (wr_row_reg == WR_ROW_LAST) begin
                            wr_row_next = '0;
                            state_next  = READ_ISSUE;
                        end else begin
                            wr_row_next = wr_row_reg + ROW_W'(1);
                        end
                    end else begin
                        wr_col_next = wr_col_reg + COL_W'(1);
                    end
                end
            end

            READ_ISSUE: begin
                read_enable  = 1'b1;
                O_BUF_COLUMN = rd_col_reg;
                O_BUF_ROW    = rd_row_reg;
                state_next   = READ_HOLD;
            end

            READ_HOLD: begin
                // The buffer registered the matrix at the previous edge and
                // holds it while read enable stays low, so backpressure only
                // needs this state to wait.
                matrix_valid = 1'b1;
                O_BUF_COLUMN = rd_col_reg;
                O_BUF_ROW    = rd_row_reg;
                if (I_MATRIX_READY) begin
                    state_next = READ_ISSUE;
                    if (rd_col_reg == RD_COL_LAST) begin
                        rd_col_next = RD_COL_FIRST;
                        if (rd_row_reg == RD_ROW_LAST) begin
                            rd_row_next = RD_ROW_FIRST;
                            frame_done  = 1'b1;
                            state_next  = FILL;
                        end else begin
                            rd_row_next = rd_row_reg + ROW_W'(1);
                        end
                    end else begin
                        rd_col_next = rd_col_reg + COL_W'(1);
                    end
                end
            end

            default: begin
                state_next = FILL;
            end
        endcase

        // Reset is synchronous, so the state may not be FILL yet during the
        // reset cycle; silence every strobe and handshake directly.
        if (I_RESET) begin
            pixel_ready  = 1'b0;
            write_enable = 1'b0;
            read_enable  = 1'b0;
            matrix_valid = 1'b0;
            frame_done   = 1'b0;
        end
    end

    assign O_PIXEL_READY      = pixel_ready;
    assign O_BUF_WRITE_ENABLE = write_enable;
    assign O_BUF_READ_ENABLE  = read_enable;
    assign O_BUF_PIXEL        = I_PIXEL;
    assign O_MATRIX_VALID     = matrix_valid;
    assign O_CENTER_COLUMN    = rd_col_reg;
    assign O_CENTER_ROW       = rd_row_reg;
    assign O_FRAME_DONE       = frame_done;

endmodule
